// File: rtl/wb_bridge_rx_master_if.sv
// Wishbone classic bus bundle between the bridge receiver master and its
// destination slave. The master drives cycle/strobe/address/data/select/we,
// the slave answers with read data, ack and err.
interface wb_bridge_rx_master_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic            wbm_cyc_o;
   logic            wbm_stb_o;
   logic            wbm_we_o;
   logic [AW-1:0]   wbm_adr_o;
   logic [DW/8-1:0] wbm_sel_o;
   logic [DW-1:0]   wbm_dat_o;
   logic [DW-1:0]   wbm_dat_i;
   logic            wbm_ack_i;
   logic            wbm_err_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i, wbm_err_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i, wbm_err_i
   );
endinterface

// File: rtl/wb_bridge_rx_master.sv
// Far-side consumer of the bridge receiver: turns each request word into one
// Wishbone classic cycle and returns a {err, data} response word. A bus
// timeout guarantees that every accepted request yields exactly one response.
module wb_bridge_rx_master #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DW/8+AW+DW:0]    rdata,
   input  logic                   vo,
   wb_bridge_rx_master_if.master  wb,
   output logic [DW:0]            sdata,
   output logic                   vi,
   input  logic                   snt,
   output logic                   busy,
   output logic                   overrun
);

   localparam int SW = DW / 8;
   localparam int PW = 1 + SW + AW + DW;

   // Last counter value before a forced error; irrelevant when the timeout is off.
   localparam logic        TO_EN_C   = (TIMEOUT > 32'sd0);
   localparam logic [15:0] TO_LAST_C = 16'((TIMEOUT > 32'sd0) ? (TIMEOUT - 32'sd1) : 32'sd0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2,
      ST_WSNT = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [15:0]     cnt_r, cnt_s;
   logic            cyc_r, cyc_s;
   logic            we_r, we_s;
   logic [AW-1:0]   adr_r, adr_s;
   logic [SW-1:0]   sel_r, sel_s;
   logic [DW-1:0]   dat_r, dat_s;
   logic [DW:0]     sdata_r, sdata_s;
   logic            vi_r, vi_s;
   logic            busy_r, busy_s;
   logic            overrun_r, overrun_s;

   // Next-state and next-output decode; every target starts from its held value.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      cyc_s     = cyc_r;
      we_s      = we_r;
      adr_s     = adr_r;
      sel_s     = sel_r;
      dat_s     = dat_r;
      sdata_s   = sdata_r;
      vi_s      = 1'b0;
      overrun_s = overrun_r;

      // A request arriving while anything is in flight is lost; remember that.
      if (vo && (state_r != ST_IDLE)) begin
         overrun_s = 1'b1;
      end else begin
         overrun_s = overrun_r;
      end

      case (state_r)
         ST_IDLE: begin
            if (vo) begin
               we_s    = rdata[PW-1];
               sel_s   = rdata[PW-2 -: SW];
               adr_s   = rdata[AW+DW-1 -: AW];
               dat_s   = rdata[DW-1:0];
               cnt_s   = 16'd0;
               cyc_s   = 1'b1;
               state_s = ST_BUS;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUS: begin
            // Slave error beats ack, and any slave answer beats the timeout.
            if (wb.wbm_err_i) begin
               sdata_s = {1'b1, {DW{1'b0}}};
               cyc_s   = 1'b0;
               vi_s    = 1'b1;
               state_s = ST_RESP;
            end else if (wb.wbm_ack_i) begin
               sdata_s = {1'b0, (we_r ? {DW{1'b0}} : wb.wbm_dat_i)};
               cyc_s   = 1'b0;
               vi_s    = 1'b1;
               state_s = ST_RESP;
            end else if (TO_EN_C && (cnt_r == TO_LAST_C)) begin
               sdata_s = {1'b1, {DW{1'b0}}};
               cyc_s   = 1'b0;
               vi_s    = 1'b1;
               state_s = ST_RESP;
            end else begin
               cnt_s   = cnt_r + 16'd1;
            end
         end
         ST_RESP: begin
            if (snt) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WSNT;
            end
         end
         ST_WSNT: begin
            if (snt) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WSNT;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cyc_s   = 1'b0;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Registered bus, response and status outputs plus the timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r     <= 16'd0;
         cyc_r     <= 1'b0;
         we_r      <= 1'b0;
         adr_r     <= {AW{1'b0}};
         sel_r     <= {SW{1'b0}};
         dat_r     <= {DW{1'b0}};
         sdata_r   <= {(DW+1){1'b0}};
         vi_r      <= 1'b0;
         busy_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         cnt_r     <= cnt_s;
         cyc_r     <= cyc_s;
         we_r      <= we_s;
         adr_r     <= adr_s;
         sel_r     <= sel_s;
         dat_r     <= dat_s;
         sdata_r   <= sdata_s;
         vi_r      <= vi_s;
         busy_r    <= busy_s;
         overrun_r <= overrun_s;
      end
   end

   assign wb.wbm_cyc_o = cyc_r;
   assign wb.wbm_stb_o = cyc_r;
   assign wb.wbm_we_o  = we_r;
   assign wb.wbm_adr_o = adr_r;
   assign wb.wbm_sel_o = sel_r;
   assign wb.wbm_dat_o = dat_r;
   assign sdata        = sdata_r;
   assign vi           = vi_r;
   assign busy         = busy_r;
   assign overrun      = overrun_r;

endmodule

// File: tb/tb_wb_bridge_rx_master.sv
// Self-checking bench for wb_bridge_rx_master: directed and random requests,
// each predicted at transaction level (bus length, response word, pulse
// positions) and compared cycle by cycle.
module tb_wb_bridge_rx_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;
   localparam int PW = 1 + DW/8 + AW + DW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [PW-1:0] rdata = '0;
   logic          vo = 1'b0;
   logic          snt = 1'b0;
   logic [DW:0]   sdata;
   logic          vi;
   logic          busy;
   logic          overrun;

   int errors = 0;
   int checks = 0;
   bit ovr_exp = 1'b0;

   wb_bridge_rx_master_if #(.DW(DW), .AW(AW)) wb ();

   wb_bridge_rx_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .reset   (reset),
      .rdata   (rdata),
      .vo      (vo),
      .wb      (wb),
      .sdata   (sdata),
      .vi      (vi),
      .snt     (snt),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // kind: 0 ack, 1 err, 2 ack+err, 3 silent slave.
   // Response is offered in bus cycle wait_n+1; snt comes snt_dly cycles after vi.
   task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [31:0] rd, input int wait_n,
                          input int kind, input int snt_dly, input bit vo_bus, input bit vo_wsnt);
      int          exp_len;
      int          t_end;
      int          cyc_cnt;
      int          vi_cnt;
      logic [32:0] exp_sd;
      bit          slave_wins;
      slave_wins = (kind != 3) && (wait_n + 1 <= TO);
      exp_len    = slave_wins ? wait_n + 1 : TO;
      if (!slave_wins || kind != 0) exp_sd = {1'b1, 32'h0};
      else                          exp_sd = {1'b0, (we ? 32'h0 : rd)};
      t_end   = exp_len + 1 + snt_dly + 2;
      cyc_cnt = 0;
      vi_cnt  = 0;

      rdata = {we, sel, adr, dat};
      vo    = 1'b1;
      step();
      for (int t = 1; t <= t_end; t++) begin
         // observe this cycle
         chk("cyc_eq_stb", 64'(wb.wbm_cyc_o), 64'(wb.wbm_stb_o));
         chk("cyc", 64'(wb.wbm_cyc_o), 64'(t <= exp_len));
         chk("vi", 64'(vi), 64'(t == exp_len + 1));
         chk("busy", 64'(busy), 64'(t <= exp_len + 1 + snt_dly));
         if (wb.wbm_cyc_o) begin
            cyc_cnt++;
            chk("bus_fields", {wb.wbm_we_o, wb.wbm_sel_o, wb.wbm_adr_o, 27'h0},
                {we, sel, adr, 27'h0});
            chk("bus_wdata", 64'(wb.wbm_dat_o), 64'(dat));
         end
         if (vi) vi_cnt++;
         if (t == exp_len + 1 || t == exp_len + 1 + snt_dly)
            chk("sdata", 64'(sdata), 64'(exp_sd));

         // drive this cycle
         vo            = 1'b0;
         rdata         = {$urandom, $urandom, $urandom};
         snt           = (t == exp_len + 1 + snt_dly);
         wb.wbm_dat_i  = $urandom;
         wb.wbm_ack_i  = 1'b0;
         wb.wbm_err_i  = 1'b0;
         if (t == wait_n + 1 && t <= exp_len && kind != 3) begin
            wb.wbm_ack_i = (kind == 0) || (kind == 2);
            wb.wbm_err_i = (kind == 1) || (kind == 2);
            wb.wbm_dat_i = rd;
         end else if (t > exp_len) begin
            wb.wbm_ack_i = ($urandom_range(3) == 0);
            wb.wbm_err_i = ($urandom_range(3) == 0);
         end
         if (vo_bus && t == 1) begin
            vo      = 1'b1;
            ovr_exp = 1'b1;
         end
         if (vo_wsnt && snt_dly >= 1 && t == exp_len + 1 + snt_dly) begin
            vo      = 1'b1;
            ovr_exp = 1'b1;
         end
         step();
      end
      snt          = 1'b0;
      vo           = 1'b0;
      wb.wbm_ack_i = 1'b0;
      wb.wbm_err_i = 1'b0;
      chk("cyc_count", 64'(cyc_cnt), 64'(exp_len));
      chk("vi_count", 64'(vi_cnt), 64'd1);
      chk("overrun", 64'(overrun), 64'(ovr_exp));
   endtask

   initial begin
      wb.wbm_dat_i = '0;
      wb.wbm_ack_i = 1'b0;
      wb.wbm_err_i = 1'b0;
      reset = 1'b1;
      step();
      step();
      chk("rst_cyc", 64'(wb.wbm_cyc_o), 64'd0);
      chk("rst_stb", 64'(wb.wbm_stb_o), 64'd0);
      chk("rst_adr", 64'(wb.wbm_adr_o), 64'd0);
      chk("rst_dat", 64'(wb.wbm_dat_o), 64'd0);
      chk("rst_sel_we", {wb.wbm_sel_o, wb.wbm_we_o}, 64'd0);
      chk("rst_sdata", 64'(sdata), 64'd0);
      chk("rst_flags", {vi, busy, overrun}, 64'd0);
      reset = 1'b0;
      step();

      // write, slave acks after two wait states
      run_txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'hCAFEF00D, 2, 0, 0, 1'b0, 1'b0);
      // read, zero-wait slave
      run_txn(1'b0, 4'hF, 32'h20, 32'h0, 32'h12345678, 0, 0, 1, 1'b0, 1'b0);
      // ack and err together
      run_txn(1'b0, 4'h3, 32'h30, 32'h0, 32'h55AA55AA, 1, 2, 0, 1'b0, 1'b0);
      // silent slave -> timeout
      run_txn(1'b1, 4'h1, 32'h40, 32'h1111, 32'h0, 0, 3, 2, 1'b0, 1'b0);
      // normal read after the timeout
      run_txn(1'b0, 4'hF, 32'h44, 32'h0, 32'hA5A5_0001, 1, 0, 0, 1'b0, 1'b0);
      // ack in the very timeout cycle: slave wins
      run_txn(1'b0, 4'hC, 32'h48, 32'h0, 32'h0BAD_CAFE, TO - 1, 0, 0, 1'b0, 1'b0);
      // dropped requests in BUS and in the WSNT exit cycle
      run_txn(1'b1, 4'h6, 32'h50, 32'h77, 32'h0, 3, 0, 2, 1'b1, 1'b1);
      repeat (3) step();
      chk("overrun_held", 64'(overrun), 64'd1);
      chk("idle_after_overrun", {busy, wb.wbm_cyc_o}, 64'd0);

      // reset in the middle of a bus cycle
      rdata = {1'b1, 4'hF, 32'h60, 32'h99};
      vo    = 1'b1;
      step();
      vo = 1'b0;
      chk("rstbus_cyc_before", 64'(wb.wbm_cyc_o), 64'd1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      ovr_exp = 1'b0;
      chk("rstbus_cyc", {wb.wbm_cyc_o, wb.wbm_stb_o}, 64'd0);
      chk("rstbus_flags", {vi, busy, overrun}, 64'd0);
      chk("rstbus_sdata", 64'(sdata), 64'd0);
      for (int i = 0; i < 4; i++) begin
         chk("rstbus_no_vi", 64'(vi), 64'd0);
         step();
      end
      run_txn(1'b0, 4'hF, 32'h64, 32'h0, 32'h600D_600D, 2, 0, 1, 1'b0, 1'b0);

      // randomized requests
      for (int n = 0; n < 24; n++) begin
         run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(10)), int'($urandom_range(3)), int'($urandom_range(3)),
                 ($urandom_range(7) == 0), ($urandom_range(7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_bridge_rx_master.md
# wb_bridge_rx_master

Far-side consumer of the 4-phase bridge receiver. Takes each request word delivered by the receiver (`rdata` qualified by the one-cycle `vo` pulse) and decodes it into write-enable, byte-select, address and write data. It then runs exactly one Wishbone classic cycle on the destination bus and hands the response word ({err, read data}) to the return-path transmitter. A bus timeout guarantees every request produces exactly one response.

## Interface
Parameters:
- `DW`, 32: Wishbone data width; multiple of 8.
- `AW`, 32: Wishbone address width.
- `TIMEOUT`, 1024: max cycles in BUS before forced error; 0 disables the timeout; limit 65535.

Derived widths:
- SW = DW/8
- PW = 1+SW+AW+DW
- Request word layout, MSB to LSB: {we, sel[SW-1:0], adr[AW-1:0], dat[DW-1:0]}

Ports:
- `clk`  in  1  single clock, rising edge; the block runs only in the receiver's clock domain.
- `reset`  in  1  synchronous, active-high.
- `rdata`  in  PW  request word from the receiver; valid only when `vo`=1.
- `vo`  in  1  one-cycle request strobe from the receiver.
- `wbm_cyc_o`, `wbm_stb_o`  out  1  bus cycle / strobe; always driven equal.
- `wbm_we_o`  out  1  write enable.
- `wbm_adr_o`  out  AW  address.
- `wbm_sel_o`  out  SW  byte selects.
- `wbm_dat_o`  out  DW  write data.
- `wbm_dat_i`  in  DW  read data.
- `wbm_ack_i`  in  1  slave acknowledge.
- `wbm_err_i`  in  1  slave error.
- `sdata`  out  DW+1  response word to the return transmitter: {err, dat}.
- `vi`  out  1  one-cycle response-valid pulse.
- `snt`  in  1  one-cycle "response delivered" pulse from the return transmitter.
- `busy`  out  1  1 in any state except IDLE.
- `overrun`  out  1  sticky; set when a request is dropped.

## Operation
States: IDLE, BUS, RESP, WSNT.

- **IDLE**
  - On `vo`: register all `rdata` fields into the wbm_* output registers.
  - Clear the timeout counter.
  - Next state BUS.
- **BUS**
  - `wbm_cyc_o` = `wbm_stb_o` = 1; address, data, select and write enable held constant.
  - Counter increments each cycle.
  - Exit on the first of `wbm_ack_i`, `wbm_err_i`, or counter = TIMEOUT-1 (TIMEOUT≠0).
  - On exit, register `sdata`:
    - ack: {0, we ? 0 : `wbm_dat_i`}
    - err: {1, 0}
    - timeout: {1, 0}
  - Next state RESP.
- **RESP**
  - `vi` = 1 for exactly this cycle; cyc/stb = 0.
  - Next state WSNT; if `snt` is already 1 in this cycle, next state is IDLE.
- **WSNT**
  - Wait for `snt`, then go to IDLE.
  - `sdata` is held stable from RESP until the cycle after `snt`.

Boundary conditions:
- `wbm_ack_i` and `wbm_err_i` high in the same cycle: err wins.
- ack/err arriving in the timeout cycle: the slave response wins over the timeout.
- ack/err while not in BUS: ignored.
- `vo` while `busy`=1: request dropped; `overrun` set to 1 and held until reset. No other effect on the transaction in flight.
- `vo` in the IDLE exit cycle of WSNT (same cycle as `snt`): dropped, overrun set, because the state is still WSNT.
- `snt` in IDLE or BUS: ignored.
- Wishbone address/data outputs retain their last values in IDLE; only cyc/stb/vi are guaranteed low.

## Timing
Reset values, applied at the first edge with `reset`=1:
- State IDLE.
- All wbm_* outputs 0, `sdata` 0, `vi` 0, `busy` 0, `overrun` 0, counter 0.

Reset during BUS drops cyc/stb at that edge. The in-flight transaction is abandoned and no response is issued.

Latency, with `vo` at cycle N:
- cyc/stb high from N+1.
- Slave ack sampled at cycle M (M ≥ N+1): cyc/stb low at M+1, `vi` pulse at M+1, `busy` low from the cycle after `snt` is sampled.
- Zero-wait slave (ack at N+1): `vi` at N+2.
- Timeout: cyc/stb high for exactly TIMEOUT cycles (N+1 … N+TIMEOUT); `vi` at N+TIMEOUT+1.

## Test plan
- Write: `vo` with we=1, sel=F, adr=0x10, dat=0xDEADBEEF, slave acks 2 cycles later -> one bus cycle with those values; `sdata`=0x0_00000000; single `vi` pulse; IDLE after `snt`.
- Read: we=0, adr=0x20, slave returns 0x12345678 with zero wait -> `vi` at N+2, `sdata`=0x0_12345678.
- Error: slave asserts ack and err in the same cycle -> `sdata`=0x1_00000000.
- Timeout: TIMEOUT=8, slave silent -> cyc high for exactly 8 cycles; `sdata`=0x1_00000000; a later normal request completes correctly.
- Overrun: second `vo` during BUS, and another in WSNT -> only the first request is executed; `overrun`=1 and held; exactly one `vi` pulse.
- Reset in BUS: `reset` pulsed mid-cycle -> cyc/stb 0 at the next edge; no `vi`; `overrun` 0; a new request then succeeds.
